// File: rtl/rf_pkg.sv
// Register-file constants and types shared by the write-back arbiter and its scoreboard.
package rf_pkg;
  localparam int RF_AW       = 5;
  localparam int RF_DW       = 32;
  localparam int RF_NREG     = 32;
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_AW-1:0]   rf_addr_t;
  typedef logic [RF_DW/8-1:0] rf_be_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per architectural register, two hazard query ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_valid,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_addr,
  input  logic          flush,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] r_busy;

  // Set is written after clear so a same-cycle set to the retiring register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (clr_valid) r_busy[clr_addr] <= 1'b0;
      if (set_valid && (set_addr != AW'(RF_ZERO_REG))) r_busy[set_addr] <= 1'b1;
    end
  end

  assign q1_busy = r_busy[q1_addr];
  assign q2_busy = r_busy[q2_addr];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter owning the register-file write port, plus busy scoreboard.
// WB_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (requester 0 highest).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ*DW-1:0]     req_data,
  input  logic [N_REQ*DW/8-1:0]   req_be,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DW/8-1:0]         rf_we,
  output logic [AW-1:0]           rf_wr,
  output logic [DW-1:0]           rf_wd,
  input  logic                    sb_set_valid,
  input  logic [AW-1:0]           sb_set_addr,
  input  logic                    sb_flush,
  input  logic [AW-1:0]           sb_q1_addr,
  input  logic [AW-1:0]           sb_q2_addr,
  output logic                    sb_q1_busy,
  output logic                    sb_q2_busy
);
  localparam int BW = DW / 8;

  logic [N_REQ-1:0] w_grant;
  logic             w_any;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [BW-1:0]    w_be;

`ifdef WB_ARB_RR_EN
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_gidx;

  // Walk from the farthest slot back to the pointer so the first valid after the pointer wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_gidx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        w_grant      = '0;
        w_grant[idx] = 1'b1;
        w_gidx       = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (w_any) r_ptr <= (w_gidx == IW'(N_REQ - 1)) ? '0 : w_gidx + IW'(1);
  end
`else
  // Isolate the lowest set valid bit.
  assign w_grant = req_valid & (~req_valid + N_REQ'(1));
`endif

  assign w_any     = |w_grant;
  assign req_ready = w_grant;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_be   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
        w_be   = req_be[i*BW +: BW];
      end
    end
  end

  logic [BW-1:0] r_we;
  logic [AW-1:0] r_wr;
  logic [DW-1:0] r_wd;
  logic          r_hs;

  // r_hs marks a retiring write even when byte enables are suppressed, so busy still clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= '0;
      r_wr <= '0;
      r_wd <= '0;
      r_hs <= 1'b0;
    end else if (w_any) begin
      r_we <= (w_addr == AW'(RF_ZERO_REG)) ? '0 : w_be;
      r_wr <= w_addr;
      r_wd <= w_data;
      r_hs <= 1'b1;
    end else begin
      r_we <= '0;
      r_hs <= 1'b0;
    end
  end

  assign rf_we = r_we;
  assign rf_wr = r_wr;
  assign rf_wd = r_wd;

  rf_scoreboard #(.AW(AW)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (sb_set_valid),
    .set_addr  (sb_set_addr),
    .clr_valid (r_hs),
    .clr_addr  (r_wr),
    .flush     (sb_flush),
    .q1_addr   (sb_q1_addr),
    .q2_addr   (sb_q2_addr),
    .q1_busy   (sb_q1_busy),
    .q2_busy   (sb_q2_busy)
  );
endmodule
